// File: rtl/ifu_fetch_queue.sv
// ifu_fetch_queue: PC generator and in-order fetch queue that drops stale responses after a redirect.
// Define IFU_MISALIGN_CHK_EN to turn a misaligned PC into a NOP fault entry instead of a request.
module ifu_fetch_queue #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int INST_BYTES = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] flush_pc_i,
  input  logic              br_redirect_i,
  input  logic [ADDR_W-1:0] br_redirect_pc_i,
  input  logic [ADDR_W-1:0] bp_next_pc_i,
  input  logic              bp_taken_i,
  output logic              req_valid_o,
  input  logic              req_ready_i,
  output logic [ADDR_W-1:0] req_addr_o,
  input  logic              rsp_valid_i,
  input  logic [INST_W-1:0] rsp_data_i,
  output logic              inst_valid_o,
  input  logic              inst_ready_i,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  output logic [ADDR_W-1:0] inst_pred_pc_o,
  output logic              inst_taken_o,
  output logic              inst_slot_end_o,
  output logic              inst_fault_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
`ifdef IFU_MISALIGN_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pred;
    logic              taken;
    logic              slot;
    logic              filled;
    logic              fault;
  } ent_t;
  ent_t [DEPTH-1:0] ent_q, ent_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic slot_q, slot_d, halt_q, halt_d;
  logic [PW-1:0] alloc_q, alloc_d, fill_q, fill_d, pop_q, pop_d;
  logic [CW-1:0] count_q, count_d, out_cnt_q, out_cnt_d, drop_cnt_q, drop_cnt_d;
  logic redirect, can_issue, misal, fire, fault_alloc, alloc, live, pop_en;
  always_comb begin
    redirect = flush_i | br_redirect_i;
    can_issue = !rst_i && !stall_i && !redirect && count_q < CW'(DEPTH) && out_cnt_q < CW'(DEPTH);
    misal = CHK && (pc_q % ADDR_W'(INST_BYTES)) != '0;
    fire = can_issue && !misal && req_ready_i;
    fault_alloc = can_issue && misal && !halt_q;
    alloc = fire | fault_alloc;
    live = rsp_valid_i && drop_cnt_q == '0;
    req_valid_o = can_issue && !misal;
    inst_valid_o = count_q != '0 && ent_q[pop_q].filled && !redirect;
    pop_en = inst_valid_o && inst_ready_i;
    ent_d = ent_q;
    if (fire)
      ent_d[alloc_q] = '{inst: '0, pc: pc_q, pred: bp_next_pc_i, taken: bp_taken_i,
                         slot: slot_q, filled: 1'b0, fault: 1'b0};
    if (fault_alloc)
      ent_d[alloc_q] = '{inst: INST_W'(32'h0000_0013), pc: pc_q, pred: pc_q + ADDR_W'(INST_BYTES),
                         taken: 1'b0, slot: slot_q, filled: 1'b1, fault: 1'b1};
    if (live) begin
      ent_d[fill_q].inst = rsp_data_i;
      ent_d[fill_q].filled = 1'b1;
    end
    out_cnt_d = out_cnt_q + CW'(fire) - CW'(rsp_valid_i);
    // Every request still in flight after a redirect belongs to the discarded stream.
    drop_cnt_d = redirect ? out_cnt_d : drop_cnt_q - CW'(rsp_valid_i && drop_cnt_q != '0);
    count_d = redirect ? '0 : count_q + CW'(alloc) - CW'(pop_en);
    alloc_d = redirect ? '0 : alloc_q + PW'(alloc);
    fill_d = redirect ? '0 : fill_q + PW'(live);
    pop_d = redirect ? '0 : pop_q + PW'(pop_en);
    pc_d = redirect ? (flush_i ? flush_pc_i : br_redirect_pc_i) : fire ? bp_next_pc_i : pc_q;
    slot_d = redirect ? br_redirect_i && !flush_i : alloc ? 1'b0 : slot_q;
    halt_d = redirect ? 1'b0 : halt_q | fault_alloc;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ent_q <= '0;
      pc_q <= RESET_PC;
      slot_q <= 1'b0;
      halt_q <= 1'b0;
      alloc_q <= '0;
      fill_q <= '0;
      pop_q <= '0;
      count_q <= '0;
      out_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      ent_q <= ent_d;
      pc_q <= pc_d;
      slot_q <= slot_d;
      halt_q <= halt_d;
      alloc_q <= alloc_d;
      fill_q <= fill_d;
      pop_q <= pop_d;
      count_q <= count_d;
      out_cnt_q <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end
  always_ff @(posedge clk_i)
    if (!rst_i) assert (!rsp_valid_i || out_cnt_q != '0);
  assign req_addr_o = pc_q;
  assign inst_o = ent_q[pop_q].inst;
  assign inst_pc_o = ent_q[pop_q].pc;
  assign inst_pred_pc_o = ent_q[pop_q].pred;
  assign inst_taken_o = ent_q[pop_q].taken;
  assign inst_slot_end_o = ent_q[pop_q].slot;
  assign inst_fault_o = CHK && ent_q[pop_q].fault;
endmodule
